// File: rtl/rt_dispatch_pkg.sv
// Shared types and default sizes for the pixel dispatch path.
package rt_dispatch_pkg;

  localparam int MAX_CORES = 4;
  localparam int X_W       = 10;
  localparam int Y_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter with clear, enable and end-of-line/frame flags.
module raster_counter #(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           x_last,
  output logic           y_last
);

  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;

  assign x      = x_reg;
  assign y      = y_reg;
  assign x_last = (x_reg == width - X_W'(1));
  assign y_last = (y_reg == height - Y_W'(1));

  // The last pixel of a frame wraps both coordinates back to the origin.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (en) begin
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_last ? '0 : y_reg + Y_W'(1);
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands raster-ordered pixel jobs round-robin to compute cores and tracks their collection.
module pixel_dispatcher #(
  parameter int MAX_CORES = rt_dispatch_pkg::MAX_CORES,
  parameter int X_W       = rt_dispatch_pkg::X_W,
  parameter int Y_W       = rt_dispatch_pkg::Y_W
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [X_W-1:0]       cfg_width,
  input  logic [Y_W-1:0]       cfg_height,
  input  logic [2:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] job_valid,
  output logic [X_W-1:0]       job_x,
  output logic [Y_W-1:0]       job_y,
  input  logic                 pix_accept,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 busy,
  output logic                 frame_done
);

  import rt_dispatch_pkg::*;

  localparam int PTR_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
  localparam int OUT_W = X_W + Y_W + 1;

  state_t               state_reg, state_next;
  logic [X_W-1:0]       width_reg;
  logic [Y_W-1:0]       height_reg;
  logic [PTR_W-1:0]     ptr_reg, ptr_last_reg, ptr_next, ptr_last_cfg;
  logic [MAX_CORES-1:0] job_valid_reg;
  logic [OUT_W-1:0]     outstanding_reg;
  logic                 coll_done_reg;

  logic                 start_ok, zero_size, hs, accept_ok, collecting;
  logic                 dx_last, dy_last, cx_last, cy_last;
  logic [X_W-1:0]       cx;
  logic [Y_W-1:0]       cy;

  assign start_ok  = (state_reg == ST_IDLE) && start;
  assign zero_size = (cfg_width == '0) || (cfg_height == '0);
  assign hs        = job_valid_reg[ptr_reg] && core_ready[ptr_reg];
  assign accept_ok = pix_accept && (outstanding_reg != '0) &&
                     ((state_reg == ST_DISPATCH) || (state_reg == ST_DRAIN));
  assign ptr_next  = (ptr_reg == ptr_last_reg) ? '0 : ptr_reg + PTR_W'(1);

  // Requests beyond the physical core count fold onto the highest core.
  always_comb begin
    ptr_last_cfg = PTR_W'(no_of_extra_cores);
    if (no_of_extra_cores >= 3'(MAX_CORES - 1))
      ptr_last_cfg = PTR_W'(MAX_CORES - 1);
  end

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_disp_cnt (
    .aclk(aclk), .aresetn(aresetn), .clr(start_ok), .en(hs),
    .width(width_reg), .height(height_reg),
    .x(job_x), .y(job_y), .x_last(dx_last), .y_last(dy_last)
  );

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_coll_cnt (
    .aclk(aclk), .aresetn(aresetn), .clr(start_ok), .en(accept_ok),
    .width(width_reg), .height(height_reg),
    .x(cx), .y(cy), .x_last(cx_last), .y_last(cy_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start) state_next = zero_size ? ST_DONE : ST_DISPATCH;
      ST_DISPATCH: if (hs && dx_last && dy_last) state_next = ST_DRAIN;
      ST_DRAIN:    if (coll_done_reg) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg != ST_IDLE);
    frame_done = (state_reg == ST_DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      width_reg       <= '0;
      height_reg      <= '0;
      ptr_reg         <= '0;
      ptr_last_reg    <= '0;
      job_valid_reg   <= '0;
      outstanding_reg <= '0;
      coll_done_reg   <= 1'b0;
    end else if (start_ok) begin
      width_reg       <= cfg_width;
      height_reg      <= cfg_height;
      ptr_reg         <= '0;
      ptr_last_reg    <= ptr_last_cfg;
      job_valid_reg   <= zero_size ? '0 : MAX_CORES'(1);
      outstanding_reg <= '0;
      coll_done_reg   <= 1'b0;
    end else begin
      if (hs) begin
        ptr_reg       <= ptr_next;
        job_valid_reg <= (dx_last && dy_last) ? '0 : (MAX_CORES'(1) << ptr_next);
      end
      outstanding_reg <= outstanding_reg + OUT_W'(hs) - OUT_W'(accept_ok);
      if (accept_ok && cx_last && cy_last)
        coll_done_reg <= 1'b1;
    end
  end

  // Flags only mean something while pixels of the current frame are still due.
  assign collecting = ((state_reg == ST_DISPATCH) || (state_reg == ST_DRAIN)) && !coll_done_reg;
  assign job_valid  = job_valid_reg;
  assign out_sof    = collecting && (cx == '0) && (cy == '0);
  assign out_eol    = collecting && cx_last;

endmodule
